// File: rtl/mul_arb_pkg.sv
// Shared types and helpers for the multiplier arbiter.
package mul_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Width of an index field able to name n requesters (at least 1 bit).
    function automatic int idw_f(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Round-robin successor of idx among n slots, wrapping n-1 -> 0.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/mul_arb_mul.sv
// Combinational unsigned N x N multiplier producing an exact 2N-bit product.
module mul_arb_mul #(
    parameter int N = 16
) (
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [2*N-1:0] p
);

    assign p = (2*N)'(a) * (2*N)'(b);

endmodule

// File: rtl/mul_arb.sv
// Round-robin arbiter sharing one multiplier between NREQ requesters.
module mul_arb
    import mul_arb_pkg::*;
#(
    parameter int N    = 16,
    parameter int NREQ = 4,
    parameter int IDW  = idw_f(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*N-1:0] req_a,
    input  logic [NREQ*N-1:0] req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [2*N-1:0]    rsp_prod,
    output logic              busy
);

    state_t             state, state_n;
    logic [IDW-1:0]     rr_ptr;
    logic [N-1:0]       a_q, b_q;
    logic [IDW-1:0]     id_q;
    logic [NREQ-1:0]    gnt;
    logic [IDW-1:0]     gnt_idx;
    logic               found;
    logic [N-1:0]       a_sel, b_sel;
    logic [2*N-1:0]     prod;
    logic               accept;

    // Priority search starting at rr_ptr, wrapping modulo NREQ.
    always_comb begin
        int idx;
        found   = 1'b0;
        gnt_idx = '0;
        gnt     = '0;
        idx     = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            for (int i = 0; i < NREQ; i++) begin
                if (!found && idx == i && req_valid[i]) begin
                    found   = 1'b1;
                    gnt_idx = IDW'(i);
                end
            end
        end
        for (int i = 0; i < NREQ; i++)
            gnt[i] = found && (gnt_idx == IDW'(i));
    end

    // Grants are only offered while idle and out of reset.
    assign req_ready = (state == IDLE && !rst) ? gnt : '0;
    assign accept    = |req_ready;
    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);

    // Operand mux for the granted requester.
    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_idx == IDW'(i)) begin
                a_sel = req_a[i*N +: N];
                b_sel = req_b[i*N +: N];
            end
        end
    end

    mul_arb_mul #(.N(N)) u_mul (
        .a (a_q),
        .b (b_q),
        .p (prod)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Next-state: accept -> one execute cycle -> hold response until taken.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept) state_n = EXEC;
            EXEC:    state_n = RESP;
            RESP:    if (rsp_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Operand capture on accept, product capture in EXEC, pointer advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr   <= '0;
            a_q      <= '0;
            b_q      <= '0;
            id_q     <= '0;
            rsp_prod <= '0;
            rsp_id   <= '0;
        end else begin
            if (state == IDLE && accept) begin
                a_q    <= a_sel;
                b_q    <= b_sel;
                id_q   <= gnt_idx;
                rr_ptr <= IDW'(rr_next(int'(gnt_idx), NREQ));
            end
            if (state == EXEC) begin
                rsp_prod <= prod;
                rsp_id   <= id_q;
            end
        end
    end

endmodule

// File: doc/mul_arb.md
Name: mul_arb

Overview:
- Round-robin arbiter and sequencer that shares one combinational N x N array multiplier (the team's MUL datapath) between NREQ requesters.
- Grants one request at a time, registers the operands, then registers the 2N-bit product.
- Returns the product with the winning requester's ID on a single valid/ready response channel.
- Sits between the issue logic of several execution lanes and the single multiplier instance.

Parameters:
- N, 16, operand width in bits; the product is 2N bits.
- NREQ, 4, number of requesters; must be >= 2.
- IDW, $clog2(NREQ), width of the requester ID field.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- req_valid  input  NREQ  per-requester request valid.
- req_ready  output  NREQ  per-requester accept; at most one bit high (one-hot or zero).
- req_a  input  NREQ*N  packed multiplicands; requester i uses bits [i*N +: N].
- req_b  input  NREQ*N  packed multipliers, same packing as req_a.
- rsp_valid  output  1  product valid.
- rsp_ready  input  1  consumer accepts the product.
- rsp_id  output  IDW  index of the requester that owns rsp_prod.
- rsp_prod  output  2N  unsigned product, a*b.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset, applied on a clk edge with rst=1, takes priority over all else, including mid-operation:
  - state=IDLE, rr_ptr=0, operand registers 0, rsp_prod=0, rsp_id=0.
  - rsp_valid=0, busy=0.
  - Any in-flight transaction is discarded silently.
  - While rst=1, req_ready must be 0.
- States: IDLE, EXEC, RESP.
- IDLE:
  - req_ready is combinational. It is a one-hot grant to the first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... with wrap modulo NREQ.
  - req_ready=0 if no req_valid is set.
  - A handshake is req_valid[i]&req_ready[i]. On it: latch a_q=req_a[i], b_q=req_b[i], id_q=i; set rr_ptr=(i+1) mod NREQ; go to EXEC.
  - rr_ptr wraps from NREQ-1 to 0.
- EXEC:
  - The MUL sub-instance sees a_q and b_q.
  - Its output is captured into rsp_prod and id_q into rsp_id.
  - Go to RESP unconditionally.
- RESP:
  - rsp_valid=1. rsp_prod and rsp_id are held stable while rsp_ready=0 (no limit on stall length).
  - On rsp_ready=1, go to IDLE.
- Latency:
  - Request handshake in cycle t gives rsp_valid=1 in cycle t+2.
  - Minimum issue interval is 3 cycles. There is no accept in the same cycle as the response handshake.
- req_ready=0 in EXEC and RESP regardless of req_valid.
  - Requesters must hold valid and operands until they are accepted.
  - The arbiter never drops a pending request.
- Fairness: with all NREQ requesters valid continuously, grants occur in order rr_ptr, rr_ptr+1, ...; each requester waits at most NREQ grants.
- Arithmetic:
  - Unsigned and exact: rsp_prod = a*b in 2N bits, with no overflow possible.
  - Operand 0 gives product 0. Max*max gives (2^N-1)^2.
- Requester deasserting valid before it is accepted is legal; the arbiter simply skips it.
- busy = (state != IDLE).

Decomposition:
- Package mul_arb_pkg:
  - state enum (IDLE, EXEC, RESP), 2-bit encoding.
  - Localparam function for IDW.
  - Round-robin "next index" function, shared with other arbiters.
- Sub-module: one instance of MUL #(N) for the product.
- The round-robin priority pick stays inline in mul_arb; no further hierarchy.

Test Plan:
- Reset mid-operation: accept req 2 (a=3, b=5), assert rst in EXEC -> next cycle rsp_valid=0, busy=0, req_ready=0; after release, req 0 (a=1, b=1) is granted first (rr_ptr=0).
- Single request: req 1 with a=16'h0012, b=16'h0034 accepted at cycle t, rsp_ready=1 -> rsp_valid at t+2 with rsp_prod=32'h000003A8, rsp_id=1; busy=0 at t+3.
- Round-robin: all four valid continuously, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0 with grants exactly 3 cycles apart; req_ready is never multi-hot.
- Backpressure: rsp_ready=0 for 5 cycles in RESP with a=16'hFFFF, b=16'hFFFF -> rsp_prod holds 32'hFFFE0001 and rsp_id is stable; req_ready stays 0 while req 3 is valid; req 3 is granted the cycle after returning to IDLE.
- Pointer wrap and skip: after a grant to 3, only req 1 and req 2 valid -> req 1 granted (pointer wrapped to 0, 0 invalid, skipped); next grant is req 2.
- Zero and identity: a=0, b=16'hABCD -> 0; a=1, b=16'hABCD -> 32'h0000ABCD; plus a random unsigned sweep compared against a reference a*b model.
